// File: rtl/imem_responder.sv
// Instruction-fetch responder: fixed-latency synchronous ROM replacement with a side load port
// and an in-order response FIFO sized so that accepted requests can never overflow it.
module imem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [63:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_instr,
    output logic                           rsp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data
);

    localparam int AW        = $clog2(DEPTH_WORDS);
    localparam int RSP_DEPTH = LATENCY + 1;
    localparam int PW        = $clog2(RSP_DEPTH);
    localparam int OW        = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR    = PW'(RSP_DEPTH - 1);
    localparam logic [OW-1:0] RSP_DEPTH_W = OW'(RSP_DEPTH);
    localparam logic [31:0]   NOP         = 32'h0000_0013;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } rsp_t;

    logic [31:0]        mem_q [DEPTH_WORDS];
    rsp_t               pipe_q [LATENCY];
    logic [LATENCY-1:0] vld_pipe_q;
    rsp_t               fifo_q [RSP_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]      fcnt_q, fcnt_d, occ_q, occ_d;

    logic          accept, rd_err, last_vld, fifo_empty, push, pop, rsp_hs;
    logic [AW-1:0] rd_idx;
    rsp_t          last_rsp, head;

    assign accept     = req_valid && req_ready;
    assign rd_idx     = req_addr[2 +: AW];
    assign rd_err     = (req_addr[1:0] != 2'b00) || (req_addr[63:AW+2] != '0);
    assign last_vld   = vld_pipe_q[LATENCY-1];
    assign last_rsp   = pipe_q[LATENCY-1];
    assign fifo_empty = (fcnt_q == '0);

    // With an empty FIFO the last stage is presented directly, keeping the latency exact;
    // it is only written into the FIFO when it cannot be consumed in the same cycle.
    assign head   = fifo_empty ? last_rsp : fifo_q[rd_ptr_q];
    assign push   = last_vld && !(fifo_empty && rsp_ready);
    assign pop    = !fifo_empty && rsp_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    assign req_ready = rst && (occ_q < RSP_DEPTH_W);
    assign rsp_valid = rst && (!fifo_empty || last_vld);
    assign rsp_instr = rsp_valid ? head.instr : '0;
    assign rsp_err   = rsp_valid ? head.err : 1'b0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        fcnt_d = fcnt_q + OW'(push) - OW'(pop);
        occ_d  = occ_q + OW'(accept) - OW'(rsp_hs);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            occ_q      <= '0;
        end else begin
            vld_pipe_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            occ_q    <= occ_d;
        end
    end

    // Read and load share the edge; the nonblocking write makes a colliding read see the old word.
    always_ff @(posedge clk) begin
        if (ld_en) mem_q[ld_addr] <= ld_data;
        if (accept) pipe_q[0] <= rd_err ? {1'b1, NOP} : {1'b0, mem_q[rd_idx]};
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        if (push) fifo_q[wr_ptr_q] <= last_rsp;
    end

endmodule
